// File: rtl/nibbler_pkg.sv
// Shared types, widths and ALU mode constants for the Nibbler control path.
package nibbler_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = INSTR_W - ADDR_W;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned ALU_S_W = 3;
  localparam int unsigned MODE_W  = ALU_S_W + 1;

  typedef enum logic [OPC_W-1:0] {
    OP_ADDI = 4'h0,
    OP_CMPI = 4'h1,
    OP_LIT  = 4'h2,
    OP_NORI = 4'h3,
    OP_ADDM = 4'h4,
    OP_CMPM = 4'h5,
    OP_LD   = 4'h6,
    OP_NORM = 4'h7,
    OP_ST   = 4'h8,
    OP_OUT  = 4'h9,
    OP_IN   = 4'hA,
    OP_JMP  = 4'hB,
    OP_JC   = 4'hC,
    OP_JNC  = 4'hD,
    OP_JZ   = 4'hE,
    OP_JNZ  = 4'hF
  } opcode_t;

  typedef enum logic [PHASE_W-1:0] {
    ST_FETCH   = 2'b00,
    ST_EXEC    = 2'b01,
    ST_WAIT_IN = 2'b10
  } ctrl_state_t;

  // ALU modes as {notCarryIn, S}; LIT and NOR ignore the carry-in bit.
  localparam logic [MODE_W-1:0]  ALU_PASS = 4'b1000;
  localparam logic [MODE_W-1:0]  ALU_CMP  = 4'b0001;
  localparam logic [ALU_S_W-1:0] ALU_LIT  = 3'b010;
  localparam logic [MODE_W-1:0]  ALU_ADD  = 4'b1011;
  localparam logic [ALU_S_W-1:0] ALU_NOR  = 3'b100;

  // Control bundle produced by the decoder for one cycle.
  typedef struct packed {
    logic [ALU_S_W-1:0] s;
    logic               notCarryIn;
    logic               notOeALU;
    logic               operandSel;
    logic               loadA;
    logic               notWeRAM;
    logic               notOeRAM;
    logic               loadOut;
    logic               inAck;
    logic               flagWe;
    logic               jumpTaken;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    s:          3'b000,
    notCarryIn: 1'b1,
    notOeALU:   1'b1,
    operandSel: 1'b0,
    loadA:      1'b0,
    notWeRAM:   1'b1,
    notOeRAM:   1'b1,
    loadOut:    1'b0,
    inAck:      1'b0,
    flagWe:     1'b0,
    jumpTaken:  1'b0
  };

  // Ops whose ALU operand comes from RAM rather than the immediate.
  function automatic logic isMemOp(input opcode_t op);
    return (op == OP_ADDM) || (op == OP_CMPM) || (op == OP_LD) || (op == OP_NORM);
  endfunction

  // Ops that latch the ALU flags at the end of EXEC.
  function automatic logic updatesFlags(input opcode_t op);
    case (op)
      OP_ADDI, OP_CMPI, OP_NORI,
      OP_ADDM, OP_CMPM, OP_NORM: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Jump decision from the flags latched by earlier instructions.
  function automatic logic isJumpTaken(input opcode_t op, input logic fNotC, input logic fNotZ);
    case (op)
      OP_JMP:  return 1'b1;
      OP_JC:   return !fNotC;
      OP_JNC:  return fNotC;
      OP_JZ:   return !fNotZ;
      OP_JNZ:  return fNotZ;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nibbler_decode.sv
// Combinational decode of state + opcode into the per-cycle control bundle.
module nibbler_decode
  import nibbler_pkg::*;
(
  input  ctrl_state_t state,
  input  opcode_t     opcode,
  input  logic        flagNotC,
  input  logic        flagNotZ,
  input  logic        inValid,
  output ctrl_t       ctrl
);

  logic [MODE_W-1:0] aluMode;

  // Strobes are only ever active in EXEC or on the completing WAIT_IN cycle.
  always_comb begin
    ctrl    = CTRL_IDLE;
    aluMode = ALU_PASS;
    case (state)
      ST_EXEC: begin
        case (opcode)
          OP_ADDI, OP_ADDM: begin
            aluMode       = ALU_ADD;
            ctrl.loadA    = 1'b1;
            ctrl.notOeALU = 1'b0;
          end
          OP_CMPI, OP_CMPM: begin
            aluMode = ALU_CMP;
          end
          OP_LIT, OP_LD: begin
            aluMode       = {1'b1, ALU_LIT};
            ctrl.loadA    = 1'b1;
            ctrl.notOeALU = 1'b0;
          end
          OP_NORI, OP_NORM: begin
            aluMode       = {1'b1, ALU_NOR};
            ctrl.loadA    = 1'b1;
            ctrl.notOeALU = 1'b0;
          end
          OP_ST: begin
            aluMode       = ALU_PASS;
            ctrl.notWeRAM = 1'b0;
          end
          OP_OUT: begin
            ctrl.loadOut = 1'b1;
          end
          OP_IN: begin
            // Input data bypasses the ALU, so notOeALU stays inactive.
            if (inValid) begin
              ctrl.loadA = 1'b1;
              ctrl.inAck = 1'b1;
            end
          end
          default: begin
          end
        endcase
        if (isMemOp(opcode)) begin
          ctrl.operandSel = 1'b1;
          ctrl.notOeRAM   = 1'b0;
        end
        ctrl.flagWe    = updatesFlags(opcode);
        ctrl.jumpTaken = isJumpTaken(opcode, flagNotC, flagNotZ);
      end
      ST_WAIT_IN: begin
        if (inValid) begin
          ctrl.loadA = 1'b1;
          ctrl.inAck = 1'b1;
        end
      end
      default: begin
      end
    endcase
    ctrl.notCarryIn = aluMode[MODE_W-1];
    ctrl.s          = aluMode[ALU_S_W-1:0];
  end

endmodule

// File: rtl/nibbler_control_fsm.sv
// Nibbler instruction sequencer: pc, ir, flag registers and fetch/exec FSM.
module nibbler_control_fsm
  import nibbler_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               aluNotC,
  input  logic               aluNotZ,
  input  logic               inValid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  ramAddr,
  output logic [ALU_S_W-1:0] S,
  output logic               notCarryIn,
  output logic               notOeALU,
  output logic               operandSel,
  output logic               loadA,
  output logic               notWeRAM,
  output logic               notOeRAM,
  output logic               loadOut,
  output logic               inAck,
  output logic               flagNotC,
  output logic               flagNotZ,
  output logic [PHASE_W-1:0] phase
);

  ctrl_state_t        state;
  ctrl_state_t        stateNext;
  logic [INSTR_W-1:0] ir;
  opcode_t            opcode;
  ctrl_t              ctrlDec;
  ctrl_t              ctrl;

  assign opcode = opcode_t'(ir[INSTR_W-1:ADDR_W]);

  nibbler_decode u_decode (
    .state    (state),
    .opcode   (opcode),
    .flagNotC (flagNotC),
    .flagNotZ (flagNotZ),
    .inValid  (inValid),
    .ctrl     (ctrlDec)
  );

  // Reset forces every strobe idle even in the cycle it is asserted.
  always_comb begin
    ctrl = ctrlDec;
    if (reset) begin
      ctrl = CTRL_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: IN without data parks in WAIT_IN until inValid rises.
  always_comb begin
    stateNext = ST_FETCH;
    case (state)
      ST_FETCH: begin
        stateNext = ST_EXEC;
      end
      ST_EXEC: begin
        if ((opcode == OP_IN) && !inValid) begin
          stateNext = ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (!inValid) begin
          stateNext = ST_WAIT_IN;
        end
      end
      default: begin
        stateNext = ST_FETCH;
      end
    endcase
  end

  // Program counter and instruction register; a taken jump overrides the fetch increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (state == ST_FETCH) begin
        ir <= instr;
        pc <= pc + ADDR_W'(1);
      end
      if (ctrl.jumpTaken) begin
        pc <= ir[ADDR_W-1:0];
      end
    end
  end

  // Flag register, written only by flag-updating ALU ops at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      flagNotC <= 1'b1;
      flagNotZ <= 1'b1;
    end else if (ctrl.flagWe) begin
      flagNotC <= aluNotC;
      flagNotZ <= aluNotZ;
    end
  end

  assign ramAddr    = ir[ADDR_W-1:0];
  assign phase      = state;
  assign S          = ctrl.s;
  assign notCarryIn = ctrl.notCarryIn;
  assign notOeALU   = ctrl.notOeALU;
  assign operandSel = ctrl.operandSel;
  assign loadA      = ctrl.loadA;
  assign notWeRAM   = ctrl.notWeRAM;
  assign notOeRAM   = ctrl.notOeRAM;
  assign loadOut    = ctrl.loadOut;
  assign inAck      = ctrl.inAck;

endmodule

// File: tb/tb_nibbler_control_fsm.sv
// Self-checking bench for nibbler_control_fsm: directed scenarios plus a randomized program run.
module tb_nibbler_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr;
  logic        aluNotC = 1'b1;
  logic        aluNotZ = 1'b1;
  logic        inValid = 1'b0;
  logic [11:0] pc;
  logic [11:0] ramAddr;
  logic [2:0]  S;
  logic        notCarryIn, notOeALU, operandSel, loadA;
  logic        notWeRAM, notOeRAM, loadOut, inAck;
  logic        flagNotC, flagNotZ;
  logic [1:0]  phase;

  logic [15:0] rom [4096];
  int          vecs = 0;
  int          errs = 0;

  localparam logic [10:0] IDLE = 11'b1_000_1_0_0_1_1_0_0;
  localparam logic [10:0] MASK_FULL = 11'h7FF;
  localparam logic [10:0] MASK_NOSEL = 11'h07F;

  // Observed control vector {notCarryIn,S,notOeALU,operandSel,loadA,notWeRAM,notOeRAM,loadOut,inAck}.
  logic [10:0] obs;
  assign obs = {notCarryIn, S, notOeALU, operandSel, loadA, notWeRAM, notOeRAM, loadOut, inAck};

  assign instr = rom[pc];

  always #5 clk = ~clk;

  nibbler_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .aluNotC    (aluNotC),
    .aluNotZ    (aluNotZ),
    .inValid    (inValid),
    .pc         (pc),
    .ramAddr    (ramAddr),
    .S          (S),
    .notCarryIn (notCarryIn),
    .notOeALU   (notOeALU),
    .operandSel (operandSel),
    .loadA      (loadA),
    .notWeRAM   (notWeRAM),
    .notOeRAM   (notOeRAM),
    .loadOut    (loadOut),
    .inAck      (inAck),
    .flagNotC   (flagNotC),
    .flagNotZ   (flagNotZ),
    .phase      (phase)
  );

  // Expected EXEC control vector from the opcode map.
  function automatic logic [10:0] expStrobes(input logic [3:0] op, input logic iv);
    logic [3:0] mode;
    logic nOeAlu, opSel, ldA, nWe, nOeR, ldOut, ack;
    mode = 4'b1000; nOeAlu = 1'b1; opSel = 1'b0; ldA = 1'b0;
    nWe = 1'b1; nOeR = 1'b1; ldOut = 1'b0; ack = 1'b0;
    if (op < 4'd8) begin
      case (op % 4)
        0:       mode = 4'b1011;
        1:       mode = 4'b0001;
        2:       mode = 4'b1010;
        default: mode = 4'b1100;
      endcase
      ldA    = (op % 4) != 1;
      nOeAlu = !ldA;
      opSel  = op >= 4'd4;
      nOeR   = !(op >= 4'd4);
    end else if (op == 4'd8) begin
      nWe = 1'b0;
    end else if (op == 4'd9) begin
      ldOut = 1'b1;
    end else if (op == 4'd10 && iv) begin
      ldA = 1'b1;
      ack = 1'b1;
    end
    return {mode, nOeAlu, opSel, ldA, nWe, nOeR, ldOut, ack};
  endfunction

  // Which bits of the vector the opcode map actually pins down.
  function automatic logic [10:0] careMask(input logic [3:0] op);
    if (op == 4'd2 || op == 4'd3 || op == 4'd6 || op == 4'd7) return 11'h3FF;
    if (op <= 4'd8) return MASK_FULL;
    return MASK_NOSEL;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; aluNotC = 1'b1; aluNotZ = 1'b1; inValid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 4096; i++) rom[i] = 16'h9000;
  endtask

  task automatic test_reset();
    clearRom();
    reset = 1'b1; aluNotC = 1'b0; aluNotZ = 1'b0; inValid = 1'b1;
    step();
    #1;
    vecs++; if (pc !== 12'h000) begin errs++; $display("FAIL reset_pc: got %h want 000", pc); end
    vecs++; if (phase !== 2'b00) begin errs++; $display("FAIL reset_phase: got %b want 00", phase); end
    vecs++; if ({flagNotC, flagNotZ} !== 2'b11) begin errs++; $display("FAIL reset_flags: got %b want 11", {flagNotC, flagNotZ}); end
    vecs++; if (obs !== IDLE) begin errs++; $display("FAIL reset_strobes: got %b want %b", obs, IDLE); end
  endtask

  task automatic test_reset_mid_exec();
    clearRom();
    rom[0] = 16'h0003;
    doReset();
    step();
    aluNotC = 1'b0; aluNotZ = 1'b0;
    #1;
    vecs++; if (loadA !== 1'b1) begin errs++; $display("FAIL addi_loadA: got %b want 1", loadA); end
    reset = 1'b1;
    #1;
    vecs++; if (loadA !== 1'b0 || notOeALU !== 1'b1) begin errs++; $display("FAIL rst_exec_strobe: got loadA=%b notOeALU=%b want 0/1", loadA, notOeALU); end
    step();
    #1;
    vecs++; if (pc !== 12'h000 || phase !== 2'b00) begin errs++; $display("FAIL rst_exec_state: got pc=%h phase=%b want 000/00", pc, phase); end
    vecs++; if ({flagNotC, flagNotZ} !== 2'b11) begin errs++; $display("FAIL rst_exec_flags: got %b want 11", {flagNotC, flagNotZ}); end
    rom[0] = 16'hA000;
    inValid = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    #1;
    vecs++; if (phase !== 2'b10) begin errs++; $display("FAIL wait_entry: got phase=%b want 10", phase); end
    reset = 1'b1;
    step();
    #1;
    vecs++; if (phase !== 2'b00 || pc !== 12'h000) begin errs++; $display("FAIL rst_wait: got phase=%b pc=%h want 00/000", phase, pc); end
  endtask

  task automatic test_lit_addi_jc();
    logic [6:1] la;
    logic [3:0] addMode;
    clearRom();
    rom[0] = 16'h200F; rom[1] = 16'h0001; rom[2] = 16'hC020;
    doReset();
    la = '0; addMode = '0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      aluNotC = (cyc == 4) ? 1'b0 : 1'b1;
      aluNotZ = 1'b1;
      #1;
      la[cyc] = loadA;
      if (cyc == 4) addMode = {notCarryIn, S};
      step();
    end
    #1;
    vecs++; if (la !== 6'b001010) begin errs++; $display("FAIL prog1_loadA: got %b want 001010", la); end
    vecs++; if (addMode !== 4'b1011) begin errs++; $display("FAIL prog1_addmode: got %b want 1011", addMode); end
    vecs++; if (flagNotC !== 1'b0) begin errs++; $display("FAIL prog1_flagNotC: got %b want 0", flagNotC); end
    vecs++; if (pc !== 12'h020 || phase !== 2'b00) begin errs++; $display("FAIL prog1_jc: got pc=%h phase=%b want 020/00", pc, phase); end
  endtask

  task automatic test_cmpi_jnz();
    logic anyLoad;
    clearRom();
    rom[0] = 16'h1005; rom[1] = 16'hF100;
    doReset();
    anyLoad = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      aluNotC = 1'b1;
      aluNotZ = (cyc == 2) ? 1'b0 : 1'b1;
      #1;
      anyLoad |= loadA;
      step();
    end
    #1;
    vecs++; if (anyLoad !== 1'b0) begin errs++; $display("FAIL cmpi_loadA: got %b want 0", anyLoad); end
    vecs++; if (flagNotZ !== 1'b0) begin errs++; $display("FAIL cmpi_flagNotZ: got %b want 0", flagNotZ); end
    vecs++; if (pc !== 12'h002) begin errs++; $display("FAIL jnz_not_taken: got pc=%h want 002", pc); end
  endtask

  task automatic test_in_wait();
    int pulses;
    logic pulseOk;
    clearRom();
    rom[0] = 16'hA000;
    doReset();
    step();
    inValid = 1'b0;
    #1;
    vecs++; if (phase !== 2'b01 || loadA !== 1'b0 || inAck !== 1'b0) begin errs++; $display("FAIL in_exec_stall: got phase=%b loadA=%b inAck=%b want 01/0/0", phase, loadA, inAck); end
    pulses = 0; pulseOk = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      step();
      inValid = (w == 3);
      #1;
      vecs++; if (phase !== 2'b10) begin errs++; $display("FAIL in_wait_phase%0d: got %b want 10", w, phase); end
      if (loadA) pulses++;
      if (w == 3 && (inAck !== 1'b1 || notOeALU !== 1'b1)) pulseOk = 1'b0;
      if (w < 3 && inAck !== 1'b0) pulseOk = 1'b0;
    end
    step();
    inValid = 1'b0;
    #1;
    if (loadA) pulses++;
    vecs++; if (pulses !== 1 || !pulseOk) begin errs++; $display("FAIL in_pulse: got pulses=%0d ackOk=%b want 1/1", pulses, pulseOk); end
    vecs++; if (phase !== 2'b00 || inAck !== 1'b0) begin errs++; $display("FAIL in_return: got phase=%b inAck=%b want 00/0", phase, inAck); end
  endtask

  task automatic test_wrap_st();
    int lowCount;
    clearRom();
    rom[0] = 16'hBFFF; rom[12'hFFF] = 16'h3005;
    doReset();
    step();
    step();
    #1;
    vecs++; if (pc !== 12'hFFF) begin errs++; $display("FAIL jmp_fff: got pc=%h want fff", pc); end
    rom[0] = 16'h8345;
    step();
    #1;
    vecs++; if (pc !== 12'h000) begin errs++; $display("FAIL pc_wrap: got pc=%h want 000", pc); end
    vecs++; if (loadA !== 1'b1 || S !== 3'b100 || notOeALU !== 1'b0) begin errs++; $display("FAIL nori_exec: got loadA=%b S=%b notOeALU=%b want 1/100/0", loadA, S, notOeALU); end
    lowCount = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      step();
      #1;
      if (notWeRAM === 1'b0) lowCount++;
      if (cyc == 1) begin
        vecs++; if (ramAddr !== 12'h345 || {notCarryIn, S} !== 4'b1000) begin errs++; $display("FAIL st_exec: got ramAddr=%h mode=%b want 345/1000", ramAddr, {notCarryIn, S}); end
      end
    end
    vecs++; if (lowCount !== 1) begin errs++; $display("FAIL st_we_width: got %0d cycles want 1", lowCount); end
  endtask

  task automatic test_lit_keeps_flags();
    clearRom();
    rom[0] = 16'h0001; rom[1] = 16'h2007;
    doReset();
    for (int cyc = 1; cyc <= 4; cyc++) begin
      aluNotC = (cyc == 2) ? 1'b0 : 1'b1;
      aluNotZ = (cyc == 2) ? 1'b0 : 1'b1;
      step();
    end
    #1;
    vecs++; if ({flagNotC, flagNotZ} !== 2'b00) begin errs++; $display("FAIL lit_flags: got %b want 00", {flagNotC, flagNotZ}); end
  endtask

  // Random program checked against an instruction-level model of pc, flags and strobes.
  task automatic test_random(input int nInstr);
    logic [11:0] mPc;
    logic        mC, mZ;
    logic [15:0] ir;
    logic [3:0]  op;
    logic        cNow, zNow, ivExec, taken, condFlag;
    logic [10:0] m, e;
    int          waits;
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    doReset();
    mPc = 12'h000; mC = 1'b1; mZ = 1'b1;
    for (int n = 0; n < nInstr; n++) begin
      aluNotC = 1'($urandom); aluNotZ = 1'($urandom); inValid = 1'($urandom);
      #1;
      vecs++; if (phase !== 2'b00 || pc !== mPc || flagNotC !== mC || flagNotZ !== mZ) begin errs++; $display("FAIL rnd_fetch[%0d]: got phase=%b pc=%h fl=%b%b want 00 %h %b%b", n, phase, pc, flagNotC, flagNotZ, mPc, mC, mZ); end
      vecs++; if ((obs & MASK_NOSEL) !== (IDLE & MASK_NOSEL)) begin errs++; $display("FAIL rnd_fetch_strobe[%0d]: got %b want %b", n, obs, IDLE); end
      ir = rom[mPc]; op = ir[15:12]; mPc = mPc + 12'd1;
      step();
      cNow = 1'($urandom); zNow = 1'($urandom); ivExec = ($urandom_range(0, 3) != 0);
      aluNotC = cNow; aluNotZ = zNow; inValid = ivExec;
      #1;
      m = careMask(op); e = expStrobes(op, ivExec);
      vecs++; if (phase !== 2'b01 || ramAddr !== ir[11:0] || (obs & m) !== (e & m)) begin errs++; $display("FAIL rnd_exec[%0d] op=%h: got phase=%b ramAddr=%h ctl=%b want 01 %h %b", n, op, phase, ramAddr, obs, ir[11:0], e); end
      if (op == 4'hA && !ivExec) begin
        waits = 0;
        do begin
          step();
          inValid = (waits >= 20) ? 1'b1 : ($urandom_range(0, 2) == 0);
          aluNotC = 1'($urandom); aluNotZ = 1'($urandom);
          #1;
          e = inValid ? expStrobes(4'hA, 1'b1) : IDLE;
          vecs++; if (phase !== 2'b10 || pc !== mPc || (obs & MASK_NOSEL) !== (e & MASK_NOSEL)) begin errs++; $display("FAIL rnd_wait[%0d]: got phase=%b pc=%h ctl=%b want 10 %h %b", n, phase, pc, obs, mPc, e); end
          waits++;
        end while (!inValid && waits < 30);
      end
      condFlag = op[1] ? mZ : mC;
      taken = (op == 4'hB) || (op >= 4'hC && condFlag == op[0]);
      if (taken) mPc = ir[11:0];
      if (op < 4'd8 && (op % 4) != 2) begin mC = cNow; mZ = zNow; end
      step();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_lit_addi_jc();
    test_cmpi_jnz();
    test_in_wait();
    test_wrap_st();
    test_lit_keeps_flags();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
